// File: rtl/ps2_mouse_device.sv
// Device-side PS/2 mouse: answers host commands and streams 3-byte movement packets.
// Open-drain lines are driven through the *_drive_low outputs; pads are built one level up.
//
// state   | meaning
// IDLE    | lines released; waiting for host RTS, a queued byte or a movement request
// TX_BIT  | device->host: bit on data line, clock released
// TX_LOW  | device->host: clock pulled low
// RX_HIGH | host->device: clock released, data sampled at end of half
// RX_LOW  | host->device: clock pulled low
// RX_ACK  | data held low for one released half, then one low clock half
// RX_DONE | decode host byte and queue the response
module ps2_mouse_device #(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP         = 8000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [8:0] move_dx,
  input  logic [8:0] move_dy,
  input  logic [2:0] move_btn,
  output logic       streaming,
  output logic       busy,
  output logic       rx_cmd_valid,
  output logic [7:0] rx_cmd,
  output logic       rx_parity_err
);

  localparam int TW = $clog2(HALF_PERIOD + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TMAX    = TW'(HALF_PERIOD - 1);
  localparam logic [GW-1:0] GAP_C   = GW'(GAP);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_BIT, S_TX_LOW, S_RX_HIGH, S_RX_LOW, S_RX_ACK, S_RX_DONE
  } state_t;

  state_t          r_state;
  logic            r_c_s1, r_c_s2, r_d_s1, r_d_s2;
  logic [GW-1:0]   r_gap;
  logic [TW-1:0]   r_tmr;
  logic [3:0]      r_idx;
  logic [10:0]     r_tx_sh;
  logic [7:0]      r_rx_sh;
  logic            r_rx_par;
  logic            r_ack_ph;
  logic [1:0]      r_settle;
  logic            r_c_low, r_d_low;
  logic            r_streaming;
  logic            r_rx_valid, r_rx_perr;
  logic [7:0]      r_rx_cmd;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_cnt;

  logic            w_tc, w_gap_ok, w_rts, w_move_ready, w_move_acc, w_par_ok;
  logic            w_flush, w_pop;
  logic [1:0]      w_push_n;
  logic [2:0][7:0] w_push_b;
  logic [CW-1:0]   w_cnt_base, w_space, w_n_acc;
  logic [AW-1:0]   w_wr_base;
  logic [7:0]      w_head;
  logic [10:0]     w_frame;

  // Two-flop synchronisers; idle level of an open-drain line is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2c_in;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d_in;
      r_d_s2 <= r_d_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     r_gap <= '0;
    else if (!(r_c_s2 && r_d_s2)) r_gap <= '0;
    else if (r_gap != GAP_C)      r_gap <= r_gap + 1'b1;
  end

  assign w_gap_ok     = (r_gap == GAP_C);
  assign w_tc         = (r_tmr == '0);
  assign w_rts        = (r_state == S_IDLE) && (r_settle == 2'd0) && r_c_s2 && !r_d_s2;
  assign w_move_ready = r_streaming && (r_cnt == '0) && (r_state == S_IDLE) && !w_rts;
  assign w_move_acc   = move_valid && w_move_ready;
  assign w_par_ok     = ^{r_rx_sh, r_rx_par};
  assign w_head       = r_mem[r_rd];
  assign w_frame      = {1'b1, ~^w_head, w_head, 1'b0};
  assign w_pop        = (r_state == S_TX_LOW) && w_tc && (r_idx == 4'd10);

  always_comb begin
    w_flush  = 1'b0;
    w_push_n = 2'd0;
    w_push_b = '0;
    if (r_state == S_RX_DONE) begin
      if (!w_par_ok) begin
        w_push_n    = 2'd1;
        w_push_b[0] = 8'hFE;
      end else if (r_rx_sh == 8'hFF) begin
        w_flush  = 1'b1;
        w_push_n = 2'd3;
        w_push_b = {8'h00, 8'hAA, 8'hFA};
      end else begin
        w_push_n    = 2'd1;
        w_push_b[0] = 8'hFA;
      end
    end else if (w_move_acc) begin
      w_push_n = 2'd3;
      w_push_b = {move_dy[7:0], move_dx[7:0],
                  {2'b00, move_dy[8], move_dx[8], 1'b1, move_btn}};
    end
  end

  // Excess pushes are dropped rather than overwriting queued bytes
  assign w_cnt_base = w_flush ? '0 : r_cnt;
  assign w_wr_base  = w_flush ? '0 : r_wr;
  assign w_space    = DEPTH_C - w_cnt_base;
  assign w_n_acc    = (CW'(w_push_n) > w_space) ? w_space : CW'(w_push_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= (w_flush ? '0 : r_rd) + AW'(w_pop);
      r_wr  <= w_wr_base + AW'(w_n_acc);
      r_cnt <= w_cnt_base + w_n_acc - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (CW'(k) < w_n_acc) r_mem[w_wr_base + AW'(k)] <= w_push_b[k];
  end

  // r_settle masks RTS detection until the synchronisers see our own release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_idx       <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_rx_par    <= 1'b0;
      r_ack_ph    <= 1'b0;
      r_settle    <= '0;
      r_c_low     <= 1'b0;
      r_d_low     <= 1'b0;
      r_streaming <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_perr   <= 1'b0;
      r_rx_cmd    <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      if (r_settle != 2'd0) r_settle <= r_settle - 2'd1;
      if (!w_tc) r_tmr <= r_tmr - 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (w_rts) begin
            r_state <= S_RX_HIGH;
            r_idx   <= '0;
            r_tmr   <= TMAX;
          end else if ((r_cnt != '0) && w_gap_ok) begin
            r_state <= S_TX_BIT;
            r_idx   <= '0;
            r_tx_sh <= w_frame;
            r_d_low <= ~w_frame[0];
            r_tmr   <= TMAX;
          end
        end
        S_TX_BIT: begin
          if (w_tc) begin
            if (!r_c_s2) begin
              r_state  <= S_IDLE;
              r_c_low  <= 1'b0;
              r_d_low  <= 1'b0;
              r_settle <= 2'd3;
            end else begin
              r_state <= S_TX_LOW;
              r_c_low <= 1'b1;
              r_tmr   <= TMAX;
            end
          end
        end
        S_TX_LOW: begin
          if (w_tc) begin
            r_c_low <= 1'b0;
            if (r_idx == 4'd10) begin
              r_state  <= S_IDLE;
              r_d_low  <= 1'b0;
              r_settle <= 2'd3;
            end else begin
              r_state <= S_TX_BIT;
              r_idx   <= r_idx + 4'd1;
              r_d_low <= ~r_tx_sh[r_idx + 4'd1];
              r_tmr   <= TMAX;
            end
          end
        end
        S_RX_HIGH: begin
          if (w_tc) begin
            if (r_idx < 4'd8)       r_rx_sh  <= {r_d_s2, r_rx_sh[7:1]};
            else if (r_idx == 4'd8) r_rx_par <= r_d_s2;
            r_tmr <= TMAX;
            if (r_idx == 4'd9) begin
              r_state  <= S_RX_ACK;
              r_ack_ph <= 1'b0;
              r_d_low  <= 1'b1;
            end else begin
              r_state <= S_RX_LOW;
              r_c_low <= 1'b1;
            end
          end
        end
        S_RX_LOW: begin
          if (w_tc) begin
            r_state <= S_RX_HIGH;
            r_c_low <= 1'b0;
            r_idx   <= r_idx + 4'd1;
            r_tmr   <= TMAX;
          end
        end
        S_RX_ACK: begin
          if (w_tc) begin
            if (!r_ack_ph) begin
              r_ack_ph <= 1'b1;
              r_c_low  <= 1'b1;
              r_tmr    <= TMAX;
            end else begin
              r_state  <= S_RX_DONE;
              r_c_low  <= 1'b0;
              r_d_low  <= 1'b0;
              r_settle <= 2'd3;
            end
          end
        end
        S_RX_DONE: begin
          r_state <= S_IDLE;
          if (w_par_ok) begin
            r_rx_valid <= 1'b1;
            r_rx_cmd   <= r_rx_sh;
            if (r_rx_sh == 8'hFF || r_rx_sh == 8'hF5) r_streaming <= 1'b0;
            else if (r_rx_sh == 8'hF4)                 r_streaming <= 1'b1;
          end else begin
            r_rx_perr <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ps2c_drive_low = r_c_low;
  assign ps2d_drive_low = r_d_low;
  assign move_ready     = w_move_ready;
  assign streaming      = r_streaming;
  assign busy           = (r_state != S_IDLE) || (r_cnt != '0);
  assign rx_cmd_valid   = r_rx_valid;
  assign rx_cmd         = r_rx_cmd;
  assign rx_parity_err  = r_rx_perr;

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Directed bench for ps2_mouse_device: a host model drives the open-drain lines and
// checks device frames against a queue of expected response bytes.
module tb_ps2_mouse_device;
  localparam int HP   = 8;
  localparam int GAPC = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [8:0] move_dx = '0;
  logic [8:0] move_dy = '0;
  logic [2:0] move_btn = '0;
  logic       streaming, busy, rx_cmd_valid, rx_parity_err;
  logic [7:0] rx_cmd;
  logic       host_c_low = 1'b0;
  logic       host_d_low = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign ps2c_in = ~(ps2c_drive_low | host_c_low);
  assign ps2d_in = ~(ps2d_drive_low | host_d_low);

  ps2_mouse_device #(.HALF_PERIOD(HP), .GAP(GAPC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_drive_low(ps2c_drive_low), .ps2d_drive_low(ps2d_drive_low),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_dx(move_dx), .move_dy(move_dy), .move_btn(move_btn),
    .streaming(streaming), .busy(busy), .rx_cmd_valid(rx_cmd_valid),
    .rx_cmd(rx_cmd), .rx_parity_err(rx_parity_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dev_c(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (ps2c_drive_low === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_dev_d(input logic lvl, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (ps2d_drive_low === lvl) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Receive one device->host frame; data sampled while the device holds clock low
  task automatic recv_byte(input string tag);
    logic [10:0] fr;
    logic [7:0]  exp;
    int          w, bad_w;
    bit          ok;
    fr = '0;
    bad_w = 0;
    for (int i = 0; i < 11; i++) begin
      wait_dev_c(1'b1, 4000, ok);
      if (!ok) begin
        check({tag, " clock pulse"}, ok, 1);
        return;
      end
      fr[i] = ps2d_in;
      w = 0;
      while (ps2c_drive_low && w < 100) begin w++; @(negedge clk); end
      if (w != HP) bad_w++;
    end
    check({tag, " framing"}, {fr[0], fr[10], ^fr[9:1]}, 3'b011);
    check({tag, " low widths"}, bad_w, 0);
    exp = 'x;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check({tag, " byte"}, fr[8:1], exp);
  endtask

  // Host->device frame: RTS, data bits changed while the device holds clock low
  task automatic send_byte(input logic [7:0] b, input bit good);
    logic [9:0] bits;
    bit ok;
    bits = {1'b1, good ? ~^b : ^b, b};
    repeat (10) @(negedge clk);
    host_d_low = 1'b1;
    repeat (4) @(negedge clk);
    host_d_low = ~bits[0];
    for (int i = 1; i < 10; i++) begin
      wait_dev_c(1'b1, 200, ok);
      if (!ok) begin check("rx clock low", ok, 1); host_d_low = 1'b0; return; end
      host_d_low = ~bits[i];
      wait_dev_c(1'b0, 200, ok);
      if (!ok) begin check("rx clock release", ok, 1); host_d_low = 1'b0; return; end
    end
    wait_dev_d(1'b1, 200, ok);
    check("rx ack seen", ok, 1);
    check("rx ack clock released", ps2c_drive_low, 0);
    wait_dev_d(1'b0, 200, ok);
    check("rx ack end", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rx_cmd_valid || rx_parity_err) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("rx pulse seen", ok, 1);
    check("rx_cmd_valid", rx_cmd_valid, good);
    check("rx_parity_err", rx_parity_err, !good);
    if (good) check("rx_cmd", rx_cmd, b);
  endtask

  initial begin
    bit ok;
    int viol_r, viol_c;

    repeat (3) @(negedge clk);
    check("reset ps2c_drive_low", ps2c_drive_low, 0);
    check("reset ps2d_drive_low", ps2d_drive_low, 0);
    check("reset streaming", streaming, 0);
    check("reset busy", busy, 0);
    check("reset move_ready", move_ready, 0);
    check("reset rx_cmd", rx_cmd, 0);
    check("reset rx_cmd_valid", rx_cmd_valid, 0);
    check("reset rx_parity_err", rx_parity_err, 0);
    rst = 1'b1;

    // Reset command: FA, AA, 00
    send_byte(8'hFF, 1'b1);
    exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    recv_byte("FF resp0");
    recv_byte("FF resp1");
    recv_byte("FF resp2");
    check("streaming after FF", streaming, 0);

    // Enable streaming, then one movement packet
    send_byte(8'hF4, 1'b1);
    exp_q.push_back(8'hFA);
    recv_byte("F4 ack");
    check("streaming after F4", streaming, 1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (move_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("move_ready offered", ok, 1);
    move_dx = 9'h005; move_dy = 9'h1FD; move_btn = 3'b001; move_valid = 1'b1;
    exp_q.push_back(8'h29); exp_q.push_back(8'h05); exp_q.push_back(8'hFD);
    check("move_ready accept cycle", move_ready, 1);
    @(negedge clk);
    move_valid = 1'b0;
    check("move_ready after accept", move_ready, 0);
    check("busy after accept", busy, 1);
    recv_byte("move b0");
    recv_byte("move b1");
    recv_byte("move b2");

    // Disable streaming; movement requests must be ignored
    send_byte(8'hF5, 1'b1);
    exp_q.push_back(8'hFA);
    recv_byte("F5 ack");
    check("streaming after F5", streaming, 0);
    move_valid = 1'b1;
    viol_r = 0; viol_c = 0;
    for (int i = 0; i < 10 * (GAPC + 22 * HP); i++) begin
      @(negedge clk);
      if (move_ready) viol_r++;
      if (ps2c_drive_low) viol_c++;
    end
    move_valid = 1'b0;
    check("move_ready while not streaming", viol_r, 0);
    check("frames while not streaming", viol_c, 0);

    // Bad parity: FE returned, streaming untouched
    send_byte(8'hF4, 1'b0);
    exp_q.push_back(8'hFE);
    recv_byte("parity resend");
    check("streaming after bad F4", streaming, 0);

    // Host inhibits the AA frame mid-way; frame restarts and order is kept
    send_byte(8'hFF, 1'b1);
    exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    recv_byte("FF2 resp0");
    for (int i = 0; i < 4; i++) begin
      wait_dev_c(1'b1, 4000, ok);
      if (ok) wait_dev_c(1'b0, 200, ok);
    end
    check("AA first bits", ok, 1);
    host_c_low = 1'b1;
    repeat (HP + 4) @(negedge clk);
    check("abort clock released", ps2c_drive_low, 0);
    check("abort data released", ps2d_drive_low, 0);
    viol_c = 0;
    repeat (3 * HP) begin
      @(negedge clk);
      if (ps2c_drive_low || ps2d_drive_low) viol_c++;
    end
    check("lines quiet while inhibited", viol_c, 0);
    check("busy with byte pending", busy, 1);
    host_c_low = 1'b0;
    recv_byte("AA resent");
    recv_byte("00 after AA");

    // Reset in the middle of a TX_LOW half
    send_byte(8'hEE, 1'b1);
    exp_q.push_back(8'hFA);
    wait_dev_c(1'b1, 4000, ok);
    check("frame started before reset", ok, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset ps2c_drive_low", ps2c_drive_low, 0);
    check("async reset ps2d_drive_low", ps2d_drive_low, 0);
    check("async reset busy", busy, 0);
    check("async reset rx_cmd", rx_cmd, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    viol_c = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2c_drive_low || busy) viol_c++;
    end
    check("idle after reset release", viol_c, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
